// File: rtl/prim_assembly_queue.sv
// Assembles vertices into triangle/rectangle primitives, queues them and emits one triangle per handshake.
// Primitive visible the cycle after its last vertex; vertex ready drops when the queue is full or on flush.

module prim_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_dat_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_dat_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-2 depth lets the pointers wrap by plain overflow.
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
endmodule

module prim_assembly_queue #(
  parameter int         COORD_W   = 16,
  parameter int         DEPTH     = 4,
  parameter logic [3:0] RECT_TYPE = 4'd7
) (
  input  logic                   iCLK,
  input  logic                   reset,
  input  logic                   iFLUSH,
  input  logic                   iVERTEX_VALID,
  output logic                   oVERTEX_READY,
  input  logic [COORD_W-1:0]     iVERTEX_X,
  input  logic [COORD_W-1:0]     iVERTEX_Y,
  input  logic [3:0]             iPRIM_TYPE,
  output logic                   oTRI_VALID,
  input  logic                   iTRI_READY,
  output logic [COORD_W-1:0]     oV0_X,
  output logic [COORD_W-1:0]     oV0_Y,
  output logic [COORD_W-1:0]     oV1_X,
  output logic [COORD_W-1:0]     oV1_Y,
  output logic [COORD_W-1:0]     oV2_X,
  output logic [COORD_W-1:0]     oV2_Y,
  output logic                   oTRI_LAST,
  output logic                   oPRIM_DONE,
  output logic [$clog2(DEPTH):0] oCOUNT,
  output logic                   oIDLE
);
  typedef struct packed {
    logic               is_rect;
    logic [COORD_W-1:0] ax, ay, bx, by, cx, cy, dx, dy;
  } prim_t;

  logic [1:0]              k_q, k_d;
  logic                    rect_q, rect_d;
  logic [2:0][COORD_W-1:0] sx_q, sx_d, sy_q, sy_d;
  logic                    half_q, half_d;
  logic                    done_q, done_d;

  logic  fifo_full, fifo_empty, push, pop;
  logic  cur_rect, vtx_acc, last_vtx, tri_hs;
  prim_t push_dat, head;

  assign oVERTEX_READY = !fifo_full & !iFLUSH;
  assign oTRI_VALID    = !fifo_empty;
  assign tri_hs        = oTRI_VALID & iTRI_READY;

  always_comb begin
    k_d      = k_q;
    rect_d   = rect_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    half_d   = half_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    push     = 1'b0;
    push_dat = '0;

    // Type is only meaningful with vertex 0; later vertices reuse the latched value.
    cur_rect = (k_q == 2'd0) ? (iPRIM_TYPE == RECT_TYPE) : rect_q;
    vtx_acc  = iVERTEX_VALID & oVERTEX_READY;
    last_vtx = cur_rect ? (k_q == 2'd3) : (k_q == 2'd2);

    push_dat.is_rect = cur_rect;
    push_dat.ax      = sx_q[0];
    push_dat.ay      = sy_q[0];
    push_dat.bx      = sx_q[1];
    push_dat.by      = sy_q[1];
    push_dat.cx      = (k_q == 2'd2) ? iVERTEX_X : sx_q[2];
    push_dat.cy      = (k_q == 2'd2) ? iVERTEX_Y : sy_q[2];
    push_dat.dx      = (k_q == 2'd3) ? iVERTEX_X : '0;
    push_dat.dy      = (k_q == 2'd3) ? iVERTEX_Y : '0;

    if (iFLUSH) begin
      k_d = 2'd0;
    end else if (vtx_acc) begin
      if (k_q == 2'd0) rect_d = cur_rect;
      if (last_vtx) begin
        push = 1'b1;
        k_d  = 2'd0;
      end else begin
        sx_d[k_q] = iVERTEX_X;
        sy_d[k_q] = iVERTEX_Y;
        k_d       = k_q + 2'd1;
      end
    end

    // A rectangle's first triangle only advances the half bit; the entry stays at the head.
    if (tri_hs) begin
      if (head.is_rect & !half_q) begin
        half_d = 1'b1;
      end else begin
        pop    = 1'b1;
        half_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (reset) begin
      k_q    <= 2'd0;
      rect_q <= 1'b0;
      sx_q   <= '0;
      sy_q   <= '0;
      half_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      rect_q <= rect_d;
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      half_q <= half_d;
      done_q <= done_d;
    end
  end

  prim_fifo #(.W($bits(prim_t)), .DEPTH(DEPTH)) u_fifo (
    .clk_i      (iCLK),
    .rst_i      (reset),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (head),
    .count_o    (oCOUNT),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign oV0_X      = head.cx;
  assign oV0_Y      = head.cy;
  assign oV1_X      = half_q ? head.bx : head.ax;
  assign oV1_Y      = half_q ? head.by : head.ay;
  assign oV2_X      = half_q ? head.dx : head.bx;
  assign oV2_Y      = half_q ? head.dy : head.by;
  assign oTRI_LAST  = !head.is_rect | half_q;
  assign oPRIM_DONE = done_q;
  assign oIDLE      = fifo_empty & (k_q == 2'd0);
endmodule

// File: tb/tb_prim_assembly_queue.sv
// Random and directed stimulus against a queue-based primitive model; outputs compared every cycle.
module tb_prim_assembly_queue;
  localparam int         CW    = 16;
  localparam int         DEPTH = 4;
  localparam logic [3:0] RT    = 4'd7;

  logic          iCLK = 1'b0;
  logic          reset, iFLUSH, iVERTEX_VALID, iTRI_READY;
  logic [CW-1:0] iVERTEX_X, iVERTEX_Y;
  logic [3:0]    iPRIM_TYPE;
  logic          oVERTEX_READY, oTRI_VALID, oTRI_LAST, oPRIM_DONE, oIDLE;
  logic [CW-1:0] oV0_X, oV0_Y, oV1_X, oV1_Y, oV2_X, oV2_Y;
  logic [2:0]    oCOUNT;

  prim_assembly_queue #(.COORD_W(CW), .DEPTH(DEPTH), .RECT_TYPE(RT)) dut (
    .iCLK(iCLK), .reset(reset), .iFLUSH(iFLUSH),
    .iVERTEX_VALID(iVERTEX_VALID), .oVERTEX_READY(oVERTEX_READY),
    .iVERTEX_X(iVERTEX_X), .iVERTEX_Y(iVERTEX_Y), .iPRIM_TYPE(iPRIM_TYPE),
    .oTRI_VALID(oTRI_VALID), .iTRI_READY(iTRI_READY),
    .oV0_X(oV0_X), .oV0_Y(oV0_Y), .oV1_X(oV1_X), .oV1_Y(oV1_Y),
    .oV2_X(oV2_X), .oV2_Y(oV2_Y), .oTRI_LAST(oTRI_LAST),
    .oPRIM_DONE(oPRIM_DONE), .oCOUNT(oCOUNT), .oIDLE(oIDLE)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    bit                 rect;
    logic [3:0][CW-1:0] x;
    logic [3:0][CW-1:0] y;
  } mprim_t;

  mprim_t mq[$];
  mprim_t stg;
  int     stg_n;
  bit     m_half, m_done;
  int     tri_seen, done_seen;
  int     n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    mprim_t h;
    chk("ready", oVERTEX_READY, !iFLUSH && mq.size() < DEPTH);
    chk("valid", oTRI_VALID, mq.size() > 0);
    chk("count", oCOUNT, mq.size());
    chk("idle", oIDLE, mq.size() == 0 && stg_n == 0);
    chk("done", oPRIM_DONE, m_done);
    if (mq.size() > 0) begin
      h = mq[0];
      chk("v0x", oV0_X, h.x[2]);
      chk("v0y", oV0_Y, h.y[2]);
      chk("v1x", oV1_X, m_half ? h.x[1] : h.x[0]);
      chk("v1y", oV1_Y, m_half ? h.y[1] : h.y[0]);
      chk("v2x", oV2_X, m_half ? h.x[3] : h.x[1]);
      chk("v2y", oV2_Y, m_half ? h.y[3] : h.y[1]);
      chk("last", oTRI_LAST, !h.rect || m_half);
    end
    if (oTRI_VALID && iTRI_READY) tri_seen++;
    if (oPRIM_DONE) done_seen++;
  endtask

  task automatic model_reset();
    mq.delete();
    stg    = '0;
    stg_n  = 0;
    m_half = 0;
    m_done = 0;
  endtask

  task automatic model_update();
    bit acc;
    if (reset) begin
      model_reset();
      return;
    end
    acc    = iVERTEX_VALID && !iFLUSH && mq.size() < DEPTH;
    m_done = 0;
    if (mq.size() > 0 && iTRI_READY) begin
      if (mq[0].rect && !m_half) m_half = 1;
      else begin
        void'(mq.pop_front());
        m_half = 0;
        m_done = 1;
      end
    end
    if (iFLUSH) stg_n = 0;
    else if (acc) begin
      if (stg_n == 0) stg.rect = (iPRIM_TYPE == RT);
      stg.x[stg_n] = iVERTEX_X;
      stg.y[stg_n] = iVERTEX_Y;
      stg_n++;
      if (stg_n == (stg.rect ? 4 : 3)) begin
        mq.push_back(stg);
        stg_n = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge iCLK);
    check_model();
    @(posedge iCLK);
    model_update();
    #1;
  endtask

  task automatic setin(input bit vld, input logic [CW-1:0] x, input logic [CW-1:0] y,
                       input logic [3:0] typ, input bit trdy, input bit flush);
    reset         = 1'b0;
    iVERTEX_VALID = vld;
    iVERTEX_X     = x;
    iVERTEX_Y     = y;
    iPRIM_TYPE    = typ;
    iTRI_READY    = trdy;
    iFLUSH        = flush;
  endtask

  task automatic cyc(input bit vld, input logic [CW-1:0] x, input logic [CW-1:0] y,
                     input logic [3:0] typ, input bit trdy, input bit flush);
    setin(vld, x, y, typ, trdy, flush);
    step();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 0);
  endtask

  int         t0, d0, idx, budget;
  int         vt[8];
  logic [3:0] sty[27];
  logic [CW-1:0] sx[27];

  initial begin
    setin(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge iCLK);
    #1;
    model_reset();
    setin(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_count", oCOUNT, 0);
    chk("rst_valid", oTRI_VALID, 0);
    chk("rst_idle", oIDLE, 1);
    chk("rst_done", oPRIM_DONE, 0);

    // Single triangle
    cyc(1, 16'h80,  16'h80,  4'd3, 1, 0);
    cyc(1, 16'h100, 16'h80,  RT,   1, 0);
    cyc(1, 16'h80,  16'h100, RT,   1, 0);
    setin(0, 0, 0, 0, 1, 0);
    #1;
    chk("tri_valid", oTRI_VALID, 1);
    chk("tri_count", oCOUNT, 1);
    chk("tri_v0", {oV0_X, oV0_Y}, {16'h80, 16'h100});
    chk("tri_v1", {oV1_X, oV1_Y}, {16'h80, 16'h80});
    chk("tri_v2", {oV2_X, oV2_Y}, {16'h100, 16'h80});
    chk("tri_last", oTRI_LAST, 1);
    step();
    chk("tri_done", oPRIM_DONE, 1);
    chk("tri_count0", oCOUNT, 0);

    // Rectangle split into two triangles
    cyc(1, 10, 10, RT,   0, 0);
    cyc(1, 50, 10, 4'd3, 0, 0);
    cyc(1, 10, 40, 4'd3, 0, 0);
    cyc(1, 50, 40, 4'd3, 0, 0);
    setin(0, 0, 0, 0, 1, 0);
    #1;
    chk("rect1_v0", {oV0_X, oV0_Y}, {16'd10, 16'd40});
    chk("rect1_v1", {oV1_X, oV1_Y}, {16'd10, 16'd10});
    chk("rect1_v2", {oV2_X, oV2_Y}, {16'd50, 16'd10});
    chk("rect1_last", oTRI_LAST, 0);
    step();
    chk("rect2_v0", {oV0_X, oV0_Y}, {16'd10, 16'd40});
    chk("rect2_v1", {oV1_X, oV1_Y}, {16'd50, 16'd10});
    chk("rect2_v2", {oV2_X, oV2_Y}, {16'd50, 16'd40});
    chk("rect2_last", oTRI_LAST, 1);
    chk("rect2_nodone", oPRIM_DONE, 0);
    step();
    chk("rect_done", oPRIM_DONE, 1);
    chk("rect_count0", oCOUNT, 0);
    step();

    // Fill to DEPTH, hold the 13th vertex, then release one slot
    for (int i = 0; i < 12; i++) cyc(1, 16'(200 + i), 16'(300 + i), 4'd3, 0, 0);
    setin(1, 16'd212, 16'd312, 4'd3, 0, 0);
    #1;
    chk("full_count", oCOUNT, 4);
    chk("full_ready", oVERTEX_READY, 0);
    step();
    cyc(1, 16'd212, 16'd312, 4'd3, 1, 0);
    setin(1, 16'd212, 16'd312, 4'd3, 0, 0);
    #1;
    chk("pop_count", oCOUNT, 3);
    chk("pop_ready", oVERTEX_READY, 1);
    step();
    cyc(1, 16'd213, 16'd313, 4'd3, 0, 0);
    cyc(1, 16'd214, 16'd314, 4'd3, 0, 0);
    drain(8);

    // Flush discards a partial primitive
    cyc(1, 16'd900, 16'd900, 4'd3, 1, 0);
    cyc(1, 16'd901, 16'd901, 4'd3, 1, 0);
    setin(1, 16'd902, 16'd902, 4'd3, 1, 1);
    #1;
    chk("flush_ready", oVERTEX_READY, 0);
    step();
    setin(0, 0, 0, 0, 0, 0);
    #1;
    chk("flush_idle", oIDLE, 1);
    cyc(1, 1, 2, 4'd3, 0, 0);
    cyc(1, 3, 4, 4'd3, 0, 0);
    cyc(1, 5, 6, 4'd3, 0, 0);
    setin(0, 0, 0, 0, 0, 0);
    #1;
    chk("flush_v0", {oV0_X, oV0_Y}, {16'd5, 16'd6});
    chk("flush_v1", {oV1_X, oV1_Y}, {16'd1, 16'd2});
    drain(3);

    // Stream of 3 rectangles and 5 triangles with ready toggling
    vt = '{3, 7, 3, 3, 7, 3, 7, 3};
    idx = 0;
    for (int p = 0; p < 8; p++) begin
      for (int v = 0; v < (vt[p] == 7 ? 4 : 3); v++) begin
        sty[idx] = (v == 0) ? 4'(vt[p]) : ((vt[p] == 7) ? 4'd1 : RT);
        sx[idx]  = 16'(1000 + idx);
        idx++;
      end
    end
    t0 = tri_seen;
    d0 = done_seen;
    idx = 0;
    budget = 0;
    while (idx < 27 && budget < 200) begin
      setin(1, sx[idx], 16'(2000 + idx), sty[idx], budget[0] == 1'b0, 0);
      if (mq.size() < DEPTH) idx++;
      step();
      budget++;
    end
    chk("stream_budget", budget < 200, 1);
    drain(16);
    chk("stream_tris", tri_seen - t0, 11);
    chk("stream_done", done_seen - d0, 8);

    // Reset with half set and two primitives queued
    for (int i = 0; i < 4; i++) cyc(1, 16'(40 + i), 16'(50 + i), (i == 0) ? RT : 4'd3, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 16'(60 + i), 16'(70 + i), 4'd3, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 16'd80, 16'd90, 4'd3, 0, 0);
    setin(0, 0, 0, 0, 1, 0);
    #1;
    chk("prerst_count", oCOUNT, 2);
    reset = 1'b1;
    step();
    setin(0, 0, 0, 0, 1, 0);
    #1;
    chk("rst2_count", oCOUNT, 0);
    chk("rst2_valid", oTRI_VALID, 0);
    chk("rst2_idle", oIDLE, 1);
    chk("rst2_done", oPRIM_DONE, 0);
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      setin($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
            ($urandom_range(0, 2) == 0) ? RT : 4'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    drain(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
